// File: rtl/dispatch_unit_pkg.sv
// Shared encodings, widths and the buffered-instruction payload for the dispatch stage.
package dispatch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned FU_W  = 2;

  localparam logic [FU_W-1:0] FU_ALU     = 2'b00;
  localparam logic [FU_W-1:0] FU_LSU     = 2'b01;
  localparam logic [FU_W-1:0] FU_MUL     = 2'b10;
  localparam logic [FU_W-1:0] FU_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [IDX_W-1:0] prd_addr;
    logic [FU_W-1:0]  fu;
  } disp_entry_t;

  localparam int unsigned ENTRY_W = $bits(disp_entry_t);

  // Illegal fu codes are still dispatched (to the ALU queue) but are tallied.
  function automatic logic is_illegal(input logic [FU_W-1:0] fu);
    return fu == FU_ILLEGAL;
  endfunction

endpackage

// File: rtl/dispatch_unit_fifo.sv
// In-order buffer of decoded instructions; flush and reset both empty it.
module disp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; flush behaves like reset for the buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + LVL_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - LVL_W'(1);
      end
    end
  end

  // Entry storage; stale contents are harmless because occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !reset_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: buffers decoded instructions and issues them in order to the ROB and one issue queue.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [XLEN-1:0]   dec_pc_i,
  input  logic [XLEN-1:0]   dec_inst_i,
  input  logic [IDX_W-1:0]  dec_prd_addr_i,
  input  logic [FU_W-1:0]   dec_fu_i,
  input  logic              flush_i,
  input  logic              rob_full_i,
  input  logic [IDX_W-1:0]  rob_idx_i,
  output logic              rob_alloc_o,
  output logic [XLEN-1:0]   rob_pc_o,
  output logic [XLEN-1:0]   rob_inst_o,
  output logic [IDX_W-1:0]  rob_prd_addr_o,
  input  logic              alu_full_i,
  input  logic              lsu_full_i,
  input  logic              mul_full_i,
  output logic              alu_push_o,
  output logic              lsu_push_o,
  output logic              mul_push_o,
  output logic [XLEN-1:0]   iq_pc_o,
  output logic [XLEN-1:0]   iq_inst_o,
  output logic [IDX_W-1:0]  iq_prd_addr_o,
  output logic [IDX_W-1:0]  iq_rob_idx_o,
  output logic [CNT_W-1:0]  dispatch_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  disp_entry_t wr_entry;
  disp_entry_t head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        accept;
  logic        dispatch;
  logic        stall;
  logic        tgt_alu;
  logic        tgt_lsu;
  logic        tgt_mul;
  logic        tgt_full;

  assign wr_entry = '{pc: dec_pc_i, inst: dec_inst_i, prd_addr: dec_prd_addr_i, fu: dec_fu_i};

  disp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .push_i  (accept),
    .wdata_i (wr_entry),
    .pop_i   (dispatch),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Head routing, dispatch decision and decoder handshake.
  always_comb begin
    tgt_alu     = 1'b0;
    tgt_lsu     = 1'b0;
    tgt_mul     = 1'b0;
    case (head.fu)
      FU_LSU:  tgt_lsu = 1'b1;
      FU_MUL:  tgt_mul = 1'b1;
      default: tgt_alu = 1'b1;
    endcase
    tgt_full    = (tgt_alu && alu_full_i) || (tgt_lsu && lsu_full_i) || (tgt_mul && mul_full_i);
    dispatch    = !reset_i && !flush_i && !fifo_empty && !rob_full_i && !tgt_full;
    stall       = !reset_i && !flush_i && !fifo_empty && !dispatch;
    dec_ready_o = !reset_i && !flush_i && !fifo_full;
    accept      = dec_valid_i && dec_ready_o;
    rob_alloc_o = dispatch;
    alu_push_o  = dispatch && tgt_alu;
    lsu_push_o  = dispatch && tgt_lsu;
    mul_push_o  = dispatch && tgt_mul;
  end

  // Payloads mirror the head entry whenever one is buffered, zero otherwise.
  always_comb begin
    rob_pc_o       = '0;
    rob_inst_o     = '0;
    rob_prd_addr_o = '0;
    iq_pc_o        = '0;
    iq_inst_o      = '0;
    iq_prd_addr_o  = '0;
    iq_rob_idx_o   = '0;
    if (!fifo_empty) begin
      rob_pc_o       = head.pc;
      rob_inst_o     = head.inst;
      rob_prd_addr_o = head.prd_addr;
      iq_pc_o        = head.pc;
      iq_inst_o      = head.inst;
      iq_prd_addr_o  = head.prd_addr;
      iq_rob_idx_o   = rob_idx_i;
    end
  end

  // Saturating statistics; flush leaves them untouched.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dispatch_cnt_o <= '0;
      stall_cnt_o    <= '0;
      illegal_cnt_o  <= '0;
    end else begin
      if (dispatch)                    dispatch_cnt_o <= sat_inc(dispatch_cnt_o);
      if (stall)                       stall_cnt_o    <= sat_inc(stall_cnt_o);
      if (dispatch && is_illegal(head.fu)) illegal_cnt_o <= sat_inc(illegal_cnt_o);
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed and random checks of dispatch_unit against a queue-based reference model.
module tb_dispatch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        reset_i, dec_valid_i, flush_i, rob_full_i;
  logic        alu_full_i, lsu_full_i, mul_full_i;
  logic [31:0] dec_pc_i, dec_inst_i;
  logic [4:0]  dec_prd_addr_i, rob_idx_i;
  logic [1:0]  dec_fu_i;

  logic        dec_ready_o, rob_alloc_o, alu_push_o, lsu_push_o, mul_push_o;
  logic [31:0] rob_pc_o, rob_inst_o, iq_pc_o, iq_inst_o;
  logic [4:0]  rob_prd_addr_o, iq_prd_addr_o, iq_rob_idx_o;
  logic [31:0] dispatch_cnt_o, stall_cnt_o, illegal_cnt_o;

  logic        q4_ready, q4_alloc, q4_alu, q4_lsu, q4_mul;
  logic [31:0] q4_rob_pc, q4_rob_inst, q4_iq_pc, q4_iq_inst;
  logic [4:0]  q4_rob_prd, q4_iq_prd, q4_iq_idx;
  logic [3:0]  q4_disp_cnt, q4_stall_cnt, q4_ill_cnt;

  always #5 clk_i = ~clk_i;

  dispatch_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_pc_i(dec_pc_i), .dec_inst_i(dec_inst_i), .dec_prd_addr_i(dec_prd_addr_i), .dec_fu_i(dec_fu_i),
    .flush_i(flush_i), .rob_full_i(rob_full_i), .rob_idx_i(rob_idx_i), .rob_alloc_o(rob_alloc_o),
    .rob_pc_o(rob_pc_o), .rob_inst_o(rob_inst_o), .rob_prd_addr_o(rob_prd_addr_o),
    .alu_full_i(alu_full_i), .lsu_full_i(lsu_full_i), .mul_full_i(mul_full_i),
    .alu_push_o(alu_push_o), .lsu_push_o(lsu_push_o), .mul_push_o(mul_push_o),
    .iq_pc_o(iq_pc_o), .iq_inst_o(iq_inst_o), .iq_prd_addr_o(iq_prd_addr_o), .iq_rob_idx_o(iq_rob_idx_o),
    .dispatch_cnt_o(dispatch_cnt_o), .stall_cnt_o(stall_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  dispatch_unit #(.BUF_DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .dec_valid_i(dec_valid_i), .dec_ready_o(q4_ready),
    .dec_pc_i(dec_pc_i), .dec_inst_i(dec_inst_i), .dec_prd_addr_i(dec_prd_addr_i), .dec_fu_i(dec_fu_i),
    .flush_i(flush_i), .rob_full_i(rob_full_i), .rob_idx_i(rob_idx_i), .rob_alloc_o(q4_alloc),
    .rob_pc_o(q4_rob_pc), .rob_inst_o(q4_rob_inst), .rob_prd_addr_o(q4_rob_prd),
    .alu_full_i(alu_full_i), .lsu_full_i(lsu_full_i), .mul_full_i(mul_full_i),
    .alu_push_o(q4_alu), .lsu_push_o(q4_lsu), .mul_push_o(q4_mul),
    .iq_pc_o(q4_iq_pc), .iq_inst_o(q4_iq_inst), .iq_prd_addr_o(q4_iq_prd), .iq_rob_idx_o(q4_iq_idx),
    .dispatch_cnt_o(q4_disp_cnt), .stall_cnt_o(q4_stall_cnt), .illegal_cnt_o(q4_ill_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  prd;
    logic [1:0]  fu;
  } ent_t;

  ent_t        q[$];
  int unsigned m_disp, m_stall, m_ill;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int unsigned sat4(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit v, input logic [1:0] fu, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [4:0] prd);
    dec_valid_i    = v;
    dec_fu_i       = fu;
    dec_pc_i       = pc;
    dec_inst_i     = inst;
    dec_prd_addr_i = prd;
  endtask

  // One clock: compare every output against the model, then advance the model across the edge.
  task automatic cycle(input string tag);
    ent_t h;
    bit   empty, exp_ready, exp_disp, to_lsu, to_mul, to_alu, tfull;
    #1;
    empty = (q.size() == 0);
    if (!empty) h = q[0];
    else begin h.pc = '0; h.inst = '0; h.prd = '0; h.fu = '0; end
    to_lsu    = !empty && (h.fu == 2'b01);
    to_mul    = !empty && (h.fu == 2'b10);
    to_alu    = !empty && !to_lsu && !to_mul;
    tfull     = to_lsu ? lsu_full_i : (to_mul ? mul_full_i : alu_full_i);
    exp_ready = !reset_i && !flush_i && (q.size() < DEPTH);
    exp_disp  = !reset_i && !flush_i && !empty && !rob_full_i && !tfull;
    check({tag, ".ready"}, dec_ready_o, exp_ready);
    check({tag, ".alloc"}, rob_alloc_o, exp_disp);
    check({tag, ".alu_push"}, alu_push_o, exp_disp && to_alu);
    check({tag, ".lsu_push"}, lsu_push_o, exp_disp && to_lsu);
    check({tag, ".mul_push"}, mul_push_o, exp_disp && to_mul);
    check({tag, ".rob_pc"}, rob_pc_o, h.pc);
    check({tag, ".rob_inst"}, rob_inst_o, h.inst);
    check({tag, ".rob_prd"}, rob_prd_addr_o, h.prd);
    check({tag, ".iq_pc"}, iq_pc_o, h.pc);
    check({tag, ".iq_inst"}, iq_inst_o, h.inst);
    check({tag, ".iq_prd"}, iq_prd_addr_o, h.prd);
    if (exp_disp) check({tag, ".iq_rob_idx"}, iq_rob_idx_o, rob_idx_i);
    check({tag, ".disp_cnt"}, dispatch_cnt_o, m_disp);
    check({tag, ".stall_cnt"}, stall_cnt_o, m_stall);
    check({tag, ".ill_cnt"}, illegal_cnt_o, m_ill);
    check({tag, ".disp_cnt4"}, q4_disp_cnt, sat4(m_disp));
    check({tag, ".stall_cnt4"}, q4_stall_cnt, sat4(m_stall));
    check({tag, ".ill_cnt4"}, q4_ill_cnt, sat4(m_ill));
    check({tag, ".alloc4"}, q4_alloc, exp_disp);
    @(posedge clk_i);
    if (reset_i) begin
      q.delete();
      m_disp = 0; m_stall = 0; m_ill = 0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (exp_disp) begin
        m_disp++;
        if (h.fu == 2'b11) m_ill++;
        void'(q.pop_front());
      end else if (!empty) begin
        m_stall++;
      end
      if (dec_valid_i && exp_ready) q.push_back('{dec_pc_i, dec_inst_i, dec_prd_addr_i, dec_fu_i});
    end
    @(negedge clk_i);
  endtask

  initial begin
    m_disp = 0; m_stall = 0; m_ill = 0;
    reset_i = 1'b1; flush_i = 1'b0; rob_full_i = 1'b0; rob_idx_i = '0;
    alu_full_i = 1'b0; lsu_full_i = 1'b0; mul_full_i = 1'b0;
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk_i);
    cycle("rst0");
    #1 check("rst.ready_in_reset", dec_ready_o, 0);
    cycle("rst1");
    reset_i = 1'b0;
    #1 check("rst.ready_after", dec_ready_o, 1);
    check("rst.disp_cnt", dispatch_cnt_o, 0);
    cycle("idle");

    // Single ALU instruction: accepted, then dispatched the next cycle.
    rob_idx_i = 5'd3;
    drive(1, 2'b00, 32'h100, 32'h0000_0033, 5'd7);
    cycle("t025_acc");
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    #1 check("t025.alloc", rob_alloc_o, 1);
    check("t025.alu_push", alu_push_o, 1);
    check("t025.iq_rob_idx", iq_rob_idx_o, 3);
    check("t025.rob_inst", rob_inst_o, 32'h33);
    cycle("t025_disp");
    check("t025.disp_cnt", dispatch_cnt_o, 1);

    // ROB full: buffer fills, stalls accumulate, then drains in order.
    rob_full_i = 1'b1;
    drive(1, 2'b00, 32'h200, 32'h1111, 5'd1);
    cycle("t026_a0");
    drive(1, 2'b01, 32'h204, 32'h2222, 5'd2);
    cycle("t026_a1");
    drive(1, 2'b10, 32'h208, 32'h3333, 5'd3);
    #1 check("t026.ready_full", dec_ready_o, 0);
    for (int i = 0; i < 3; i++) cycle("t026_hold");
    check("t026.stall_cnt", stall_cnt_o, 4);
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    rob_full_i = 1'b0;
    #1 check("t026.first_alu", alu_push_o, 1);
    check("t026.first_pc", rob_pc_o, 32'h200);
    cycle("t026_d0");
    #1 check("t026.second_lsu", lsu_push_o, 1);
    check("t026.second_pc", rob_pc_o, 32'h204);
    cycle("t026_d1");

    // Stalled MUL head blocks a younger ALU entry.
    mul_full_i = 1'b1;
    drive(1, 2'b10, 32'h300, 32'h4444, 5'd4);
    cycle("t027_a0");
    drive(1, 2'b00, 32'h304, 32'h5555, 5'd5);
    cycle("t027_a1");
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    #1 check("t027.no_bypass", alu_push_o, 0);
    cycle("t027_s0");
    cycle("t027_s1");
    mul_full_i = 1'b0;
    #1 check("t027.mul_first", mul_push_o, 1);
    cycle("t027_d0");
    #1 check("t027.alu_second", alu_push_o, 1);
    check("t027.alu_pc", rob_pc_o, 32'h304);
    cycle("t027_d1");

    // Flush with two entries buffered.
    rob_full_i = 1'b1;
    drive(1, 2'b01, 32'h500, 32'h6666, 5'd6);
    cycle("t028_a0");
    drive(1, 2'b10, 32'h504, 32'h7777, 5'd8);
    cycle("t028_a1");
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    rob_full_i = 1'b0;
    flush_i = 1'b1;
    #1 check("t028.no_alloc", rob_alloc_o, 0);
    cycle("t028_flush");
    flush_i = 1'b0;
    #1 check("t028.empty_pc", rob_pc_o, 0);
    check("t028.ready", dec_ready_o, 1);
    check("t028.disp_cnt", dispatch_cnt_o, 5);
    cycle("t028_after");

    // Illegal fu code goes to the ALU queue and is counted.
    drive(1, 2'b11, 32'h600, 32'hFFFF_FFFF, 5'd9);
    cycle("t029_acc");
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    #1 check("t029.alu_push", alu_push_o, 1);
    cycle("t029_disp");
    check("t029.ill_cnt", illegal_cnt_o, 1);

    // Randomized traffic with back-pressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 6), 2'($urandom), $urandom, $urandom, 5'($urandom));
      flush_i    = ($urandom_range(0, 19) == 0);
      rob_full_i = ($urandom_range(0, 3) == 0);
      alu_full_i = ($urandom_range(0, 3) == 0);
      lsu_full_i = ($urandom_range(0, 3) == 0);
      mul_full_i = ($urandom_range(0, 3) == 0);
      rob_idx_i  = 5'($urandom);
      cycle("rnd");
    end
    check("t030.disp_cnt4_sat", q4_disp_cnt, 4'hF);

    // Reset in the middle of operation with one entry buffered.
    flush_i = 1'b0; alu_full_i = 1'b0; lsu_full_i = 1'b0; mul_full_i = 1'b0;
    rob_full_i = 1'b1;
    drive(1, 2'b00, 32'h700, 32'h8888, 5'd10);
    cycle("t030_acc");
    drive(0, 2'b00, 32'h0, 32'h0, 5'd0);
    rob_full_i = 1'b0;
    reset_i = 1'b1;
    #1 check("t030.rst_alloc", rob_alloc_o, 0);
    check("t030.rst_alu", alu_push_o, 0);
    check("t030.rst_ready", dec_ready_o, 0);
    cycle("t030_rst");
    reset_i = 1'b0;
    #1 check("t030.ready_after", dec_ready_o, 1);
    check("t030.disp_cnt", dispatch_cnt_o, 0);
    check("t030.stall_cnt", stall_cnt_o, 0);
    check("t030.disp_cnt4", q4_disp_cnt, 0);
    check("t030.empty_pc", rob_pc_o, 0);
    cycle("t030_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
